// File: rtl/pipeline_if.sv
// Instruction-fetch stage: owns the PC, drives the req/ack fetch port and the IF/ID register.
// Optional misaligned-target trap enabled by defining PIPELINE_IF_MISALIGN_EN.
module pipeline_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  input  logic [4:0]  stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        stall_req_o,
  output logic        misalign_o
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_KILL, S_ERR} state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_buf;
  logic [XLEN-1:0]   r_redirect;
  logic [XLEN-1:0]   r_inst;
  logic [XLEN-1:0]   r_pc_o;
  logic              r_misalign;

  state_t            w_state_n;
  logic [XLEN-1:0]   w_pc_n;
  logic [XLEN-1:0]   w_buf_n;
  logic [XLEN-1:0]   w_redirect_n;
  logic [XLEN-1:0]   w_inst_n;
  logic [XLEN-1:0]   w_pc_o_n;
  logic              w_misalign_n;
  logic              w_deliver;
  logic [XLEN-1:0]   w_deliver_data;
  logic [XLEN-1:0]   w_target;
  logic              w_misaligned;
  logic [XLEN-1:0]   w_pc_inc;
  logic              w_stall;
  logic              w_unused;

`ifdef PIPELINE_IF_MISALIGN_EN
  assign w_target     = branch_target_i;
  assign w_misaligned = branch_i & (branch_target_i[1:0] != 2'b00);
  assign w_unused     = ^{stall_i[4:2], stall_i[0]};
`else
  assign w_target     = {branch_target_i[31:2], 2'b00};
  assign w_misaligned = 1'b0;
  assign w_unused     = ^{stall_i[4:2], stall_i[0], branch_target_i[1:0]};
`endif

  assign w_stall  = stall_i[1];
  assign w_pc_inc = r_pc + XLEN'(4);

  // Next-state, PC and IF/ID register update
  always_comb begin
    w_state_n      = r_state;
    w_pc_n         = r_pc;
    w_buf_n        = r_buf;
    w_redirect_n   = r_redirect;
    w_misalign_n   = r_misalign | w_misaligned;
    w_deliver      = 1'b0;
    w_deliver_data = '0;
    w_inst_n       = '0;
    w_pc_o_n       = r_pc_o;

    case (r_state)
      S_FETCH: begin
        if (mem_ack_i) begin
          if (branch_i) begin
            w_pc_n    = w_target;
            w_state_n = w_misaligned ? S_ERR : S_FETCH;
          end else if (!w_stall) begin
            w_deliver      = 1'b1;
            w_deliver_data = mem_data_i;
            w_pc_n         = w_pc_inc;
          end else begin
            w_buf_n   = mem_data_i;
            w_state_n = S_HOLD;
          end
        end else if (branch_i) begin
          w_redirect_n = w_target;
          w_state_n    = S_KILL;
        end
      end
      S_HOLD: begin
        if (branch_i) begin
          w_pc_n    = w_target;
          w_state_n = w_misaligned ? S_ERR : S_FETCH;
        end else if (!w_stall) begin
          w_deliver      = 1'b1;
          w_deliver_data = r_buf;
          w_pc_n         = w_pc_inc;
          w_state_n      = S_FETCH;
        end
      end
      S_KILL: begin
        // Wrong-path request must complete before the redirect takes effect
        if (branch_i) begin
          w_redirect_n = w_target;
        end
        if (mem_ack_i) begin
          w_pc_n    = branch_i ? w_target : r_redirect;
          w_state_n = w_misalign_n ? S_ERR : S_FETCH;
        end
      end
      default: begin
        w_state_n = S_ERR;
      end
    endcase

    if (branch_i) begin
      w_inst_n = '0;
    end else if (w_stall) begin
      w_inst_n = r_inst;
    end else if (w_deliver) begin
      w_inst_n = w_deliver_data;
      w_pc_o_n = r_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_buf      <= '0;
      r_redirect <= '0;
      r_inst     <= '0;
      r_pc_o     <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_pc       <= w_pc_n;
      r_buf      <= w_buf_n;
      r_redirect <= w_redirect_n;
      r_inst     <= w_inst_n;
      r_pc_o     <= w_pc_o_n;
      r_misalign <= w_misalign_n;
    end
  end

  assign mem_req_o   = ~rst & ((r_state == S_FETCH) | (r_state == S_KILL));
  assign mem_addr_o  = r_pc;
  assign stall_req_o = ~rst & (((r_state == S_FETCH) & ~mem_ack_i) | (r_state == S_KILL));
  assign inst_o      = r_inst;
  assign pc_o        = r_pc_o;
  assign misalign_o  = r_misalign;

endmodule

// File: tb/tb_pipeline_if.sv
// Bench for pipeline_if: vector table with a fetch scoreboard, plus misalign and reset sequences.
module tb_pipeline_if;

  logic        clk;
  logic        rst;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic [4:0]  stall_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        stall_req_o;
  logic        misalign_o;

  pipeline_if #(.RESET_PC(32'h0000_0100)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_ack_i       (mem_ack_i),
    .mem_data_i      (mem_data_i),
    .stall_i         (stall_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .inst_o          (inst_o),
    .pc_o            (pc_o),
    .stall_req_o     (stall_req_o),
    .misalign_o      (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 nothing fetched, 1 fetched and delivered, 2 fetched into buffer, 3 buffer delivered
  typedef struct {
    logic        ack;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        sreq;
    logic [1:0]  kind;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  localparam int NV = 29;
  vec_t vecs [NV];
  exp_t sb [$];
  int   n_vec;
  int   n_err;
  logic [31:0] exp_inst;
  logic [31:0] exp_pco;

  function automatic logic [31:0] dmem(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic vec_t mk(input logic ack, input logic stall, input logic br,
                              input logic [31:0] tgt, input logic req,
                              input logic [31:0] addr, input logic sreq,
                              input logic [1:0] kind);
    vec_t v;
    v.ack = ack; v.stall = stall; v.br = br; v.tgt = tgt;
    v.req = req; v.addr = addr; v.sreq = sreq; v.kind = kind;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ack, input logic stall, input logic br,
                       input logic [31:0] tgt, input logic [31:0] data);
    mem_ack_i       = ack;
    stall_i         = {3'($urandom), stall, 1'($urandom)};
    branch_i        = br;
    branch_target_i = tgt;
    mem_data_i      = data;
  endtask

  initial begin
    vec_t v;
    exp_t e;
    n_vec = 0;
    n_err = 0;
    // zero-wait fetches from RESET_PC
    vecs[0]  = mk(1, 0, 0, 32'h0,         1, 32'h100,       0, 2'd1);
    vecs[1]  = mk(1, 0, 0, 32'h0,         1, 32'h104,       0, 2'd1);
    vecs[2]  = mk(1, 0, 0, 32'h0,         1, 32'h108,       0, 2'd1);
    // ack every third cycle
    vecs[3]  = mk(0, 0, 0, 32'h0,         1, 32'h10C,       1, 2'd0);
    vecs[4]  = mk(0, 0, 0, 32'h0,         1, 32'h10C,       1, 2'd0);
    vecs[5]  = mk(1, 0, 0, 32'h0,         1, 32'h10C,       0, 2'd1);
    vecs[6]  = mk(0, 0, 0, 32'h0,         1, 32'h110,       1, 2'd0);
    vecs[7]  = mk(0, 0, 0, 32'h0,         1, 32'h110,       1, 2'd0);
    vecs[8]  = mk(1, 0, 0, 32'h0,         1, 32'h110,       0, 2'd1);
    // ack under load-use stall, then HOLD, then release
    vecs[9]  = mk(1, 1, 0, 32'h0,         1, 32'h114,       0, 2'd2);
    vecs[10] = mk(0, 1, 0, 32'h0,         0, 32'h114,       0, 2'd0);
    vecs[11] = mk(0, 0, 0, 32'h0,         0, 32'h114,       0, 2'd3);
    vecs[12] = mk(1, 0, 0, 32'h0,         1, 32'h118,       0, 2'd1);
    // branch while fetch pending: wrong-path ack dropped in KILL
    vecs[13] = mk(0, 0, 1, 32'h200,       1, 32'h11C,       1, 2'd0);
    vecs[14] = mk(0, 0, 0, 32'h0,         1, 32'h11C,       1, 2'd0);
    vecs[15] = mk(1, 0, 0, 32'h0,         1, 32'h11C,       1, 2'd0);
    vecs[16] = mk(1, 0, 0, 32'h0,         1, 32'h200,       0, 2'd1);
    // branch and stall on the same edge as an ack
    vecs[17] = mk(1, 1, 1, 32'h300,       1, 32'h204,       0, 2'd0);
    vecs[18] = mk(1, 0, 0, 32'h0,         1, 32'h300,       0, 2'd1);
    // branch out of HOLD drops the buffered word
    vecs[19] = mk(1, 1, 0, 32'h0,         1, 32'h304,       0, 2'd0);
    vecs[20] = mk(0, 1, 1, 32'h400,       0, 32'h304,       0, 2'd0);
    vecs[21] = mk(1, 0, 0, 32'h0,         1, 32'h400,       0, 2'd1);
    // second branch in KILL overrides the redirect
    vecs[22] = mk(0, 0, 1, 32'h500,       1, 32'h404,       1, 2'd0);
    vecs[23] = mk(0, 0, 1, 32'h600,       1, 32'h404,       1, 2'd0);
    vecs[24] = mk(1, 0, 0, 32'h0,         1, 32'h404,       1, 2'd0);
    vecs[25] = mk(1, 0, 0, 32'h0,         1, 32'h600,       0, 2'd1);
    // PC wraps modulo 2^32
    vecs[26] = mk(1, 0, 1, 32'hFFFF_FFFC, 1, 32'h604,       0, 2'd0);
    vecs[27] = mk(1, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 2'd1);
    vecs[28] = mk(1, 0, 0, 32'h0,         1, 32'h0,         0, 2'd1);

    rst = 1'b0;
    drive(0, 0, 0, 32'h0, 32'h0);
    #1 rst = 1'b1;
    #6;
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_pc_o", pc_o, 32'h0);
    chk("rst_req", 32'(mem_req_o), 32'h0);
    chk("rst_sreq", 32'(stall_req_o), 32'h0);
    chk("rst_misalign", 32'(misalign_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_inst = 32'h0;
    exp_pco  = 32'h0;

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      @(negedge clk);
      drive(v.ack, v.stall, v.br, v.tgt, dmem(v.addr));
      #1;
      chk($sformatf("v%0d_req", i), 32'(mem_req_o), 32'(v.req));
      chk($sformatf("v%0d_addr", i), mem_addr_o, v.addr);
      chk($sformatf("v%0d_sreq", i), 32'(stall_req_o), 32'(v.sreq));
      if (v.kind == 2'd1 || v.kind == 2'd2) sb.push_back('{dmem(v.addr), v.addr});
      @(posedge clk);
      #1;
      if (v.kind == 2'd1 || v.kind == 2'd3) begin
        if (sb.size() == 0) begin
          chk($sformatf("v%0d_sb_empty", i), 32'(sb.size()), 32'h1);
        end else begin
          e = sb.pop_front();
          exp_inst = e.inst;
          exp_pco  = e.pc;
        end
      end else if (!(v.stall && !v.br)) begin
        exp_inst = 32'h0;
      end
      chk($sformatf("v%0d_inst", i), inst_o, exp_inst);
      chk($sformatf("v%0d_pc_o", i), pc_o, exp_pco);
      chk($sformatf("v%0d_misalign", i), 32'(misalign_o), 32'h0);
    end
    chk("sb_drained", 32'(sb.size()), 32'h0);

    // misaligned branch target 0x202 from FETCH at pc 4
    @(negedge clk);
    drive(1, 0, 1, 32'h202, dmem(32'h4));
    #1;
    chk("mis_req", 32'(mem_req_o), 32'h1);
    chk("mis_addr", mem_addr_o, 32'h4);
    @(posedge clk);
    #1;
    chk("mis_inst", inst_o, 32'h0);
    chk("mis_pc_o", pc_o, 32'h0);
`ifdef PIPELINE_IF_MISALIGN_EN
    chk("mis_flag", 32'(misalign_o), 32'h1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(0, 0, 0, 32'h0, 32'h0);
      #1;
      chk($sformatf("err%0d_req", k), 32'(mem_req_o), 32'h0);
      chk($sformatf("err%0d_sreq", k), 32'(stall_req_o), 32'h0);
      @(posedge clk);
      #1;
      chk($sformatf("err%0d_inst", k), inst_o, 32'h0);
      chk($sformatf("err%0d_flag", k), 32'(misalign_o), 32'h1);
    end
`else
    chk("mis_flag", 32'(misalign_o), 32'h0);
    @(negedge clk);
    drive(1, 0, 0, 32'h0, dmem(32'h200));
    #1;
    chk("mis_next_req", 32'(mem_req_o), 32'h1);
    chk("mis_next_addr", mem_addr_o, 32'h200);
    @(posedge clk);
    #1;
    chk("mis_next_inst", inst_o, dmem(32'h200));
    chk("mis_next_pc_o", pc_o, 32'h200);
`endif

    // asynchronous reset mid-cycle, then restart from RESET_PC
    @(negedge clk);
    drive(0, 0, 0, 32'h0, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("arst_inst", inst_o, 32'h0);
    chk("arst_pc_o", pc_o, 32'h0);
    chk("arst_req", 32'(mem_req_o), 32'h0);
    chk("arst_misalign", 32'(misalign_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 0, 32'h0, dmem(32'h100));
    #1;
    chk("arst_addr", mem_addr_o, 32'h100);
    chk("arst_req2", 32'(mem_req_o), 32'h1);
    @(posedge clk);
    #1;
    chk("arst_first_inst", inst_o, dmem(32'h100));
    chk("arst_first_pc_o", pc_o, 32'h100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
